// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
// The decoder and the unit use the same op codes from this package.
// Contents: data width, default busy lengths, op encodings and
// the FSM state type that the unit exposes for debug.
package md_pkg;

  localparam int MD_W          = 32;
  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
  // Wide enough for any practical MUL_CYCLES / DIV_CYCLES setting.
  localparam int MD_CNT_W      = 16;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_if.sv
// Issue/result bundle between the EX stage and the multiply-divide unit.
// Handshake: an op is accepted on a rising edge where start=1, busy=0 and
// op<=5; the master need not hold start once busy rises, and any start seen
// while busy=1 is dropped (no queueing). hi_out/lo_out are valid whenever
// busy=0.
//   start  master->slave  issue request
//   op     master->slave  md_pkg op code
//   a, b   master->slave  rs / rt operands
//   busy   slave->master  operation in flight
//   hi_out slave->master  HI register
//   lo_out slave->master  LO register
interface md_if;
  logic                    start;
  logic [2:0]              op;
  logic [md_pkg::MD_W-1:0] a;
  logic [md_pkg::MD_W-1:0] b;
  logic                    busy;
  logic [md_pkg::MD_W-1:0] hi_out;
  logic [md_pkg::MD_W-1:0] lo_out;

  modport master (output start, op, a, b, input busy, hi_out, lo_out);
  modport slave  (input start, op, a, b, output busy, hi_out, lo_out);
endinterface

// File: rtl/md_signed_div.sv
// Combinational 32-bit divide, signed or unsigned.
// Signed mode divides magnitudes, then fixes signs: the quotient is
// negative when the operand signs differ (truncation toward zero), the
// remainder takes the sign of the dividend. 0x80000000 / -1 wraps to
// 0x80000000 with remainder 0. A zero divisor yields zeros; the caller
// ignores the result in that case.
//   i_a      dividend
//   i_b      divisor
//   i_signed 1 = signed divide
//   o_q      quotient
//   o_r      remainder
module md_signed_div import md_pkg::*; (
  input  logic [MD_W-1:0] i_a,
  input  logic [MD_W-1:0] i_b,
  input  logic            i_signed,
  output logic [MD_W-1:0] o_q,
  output logic [MD_W-1:0] o_r
);
  logic            w_a_neg;
  logic            w_b_neg;
  logic [MD_W-1:0] w_a_mag;
  logic [MD_W-1:0] w_b_mag;
  logic [MD_W-1:0] w_q_mag;
  logic [MD_W-1:0] w_r_mag;

  always_comb begin
    w_a_neg = i_signed & i_a[MD_W-1];
    w_b_neg = i_signed & i_b[MD_W-1];
    w_a_mag = w_a_neg ? -i_a : i_a;
    w_b_mag = w_b_neg ? -i_b : i_b;
    if (w_b_mag == '0) begin
      w_q_mag = '0;
      w_r_mag = '0;
    end else begin
      w_q_mag = w_a_mag / w_b_mag;
      w_r_mag = w_a_mag % w_b_mag;
    end
    o_q = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    o_r = w_a_neg ? -w_r_mag : w_r_mag;
  end
endmodule

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit beside the EX-stage ALU.
// MULT/MULTU/DIV/DIVU run for MUL_CYCLES / DIV_CYCLES cycles with busy high;
// MTHI/MTLO write HI/LO in one cycle without raising busy.
//   clk         rising-edge clock
//   reset       synchronous, active-high; aborts any op in flight
//   bus         md_if slave: start/op/a/b in, busy/hi_out/lo_out out
//   o_dbg_state current FSM state
module md_unit import md_pkg::*; #(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic      clk,
  input  logic      reset,
  md_if.slave       bus,
  output md_state_e o_dbg_state
);
  md_state_e           r_state;
  logic [MD_CNT_W-1:0] r_cnt;
  logic                r_busy;
  logic                r_signed;
  logic [MD_W-1:0]     r_a;
  logic [MD_W-1:0]     r_b;
  logic [MD_W-1:0]     r_hi;
  logic [MD_W-1:0]     r_lo;

  logic [2*MD_W-1:0]   w_ext_a;
  logic [2*MD_W-1:0]   w_ext_b;
  logic [2*MD_W-1:0]   w_prod;
  logic [MD_W-1:0]     w_q;
  logic [MD_W-1:0]     w_r;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then correct for both signed and unsigned multiply.
  always_comb begin
    w_ext_a = {{MD_W{r_signed & r_a[MD_W-1]}}, r_a};
    w_ext_b = {{MD_W{r_signed & r_b[MD_W-1]}}, r_b};
    w_prod  = w_ext_a * w_ext_b;
  end

  md_signed_div u_div (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_signed (r_signed),
    .o_q      (w_q),
    .o_r      (w_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_signed <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            case (md_op_e'(bus.op))
              MD_MTHI: r_hi <= bus.a;
              MD_MTLO: r_lo <= bus.a;
              MD_MULT, MD_MULTU: begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_signed <= (md_op_e'(bus.op) == MD_MULT);
                r_cnt    <= MD_CNT_W'(MUL_CYCLES);
                r_busy   <= 1'b1;
                r_state  <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_signed <= (md_op_e'(bus.op) == MD_DIV);
                r_cnt    <= MD_CNT_W'(DIV_CYCLES);
                r_busy   <= 1'b1;
                r_state  <= ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          r_cnt <= r_cnt - MD_CNT_W'(1);
          // Last busy cycle: commit the result and release the stall.
          if (r_cnt == MD_CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (r_state == ST_MUL) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_b != '0) begin
              r_hi <= w_r;
              r_lo <= w_q;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.hi_out  = r_hi;
  assign bus.lo_out  = r_lo;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases from the design notes plus a randomized
// run against a 64-bit arithmetic reference model.
module tb_md_unit import md_pkg::*;;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic      clk;
  logic      reset;
  md_state_e dbg_state;
  md_if      bus ();

  md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] exp_q[$];

  function automatic int op_cycles(input int op);
    if (op == 0 || op == 1) return MUL_N;
    if (op == 2 || op == 3) return DIV_N;
    return 0;
  endfunction

  function automatic void model_op(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    longint      sq;
    longint      sr;
    case (op)
      0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(sp);
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      1: begin
        up = 64'(a) * 64'(b);
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      2: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        m_lo = 32'(sq);
        m_hi = 32'(sr);
      end
      3: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      4: m_hi = a;
      5: m_lo = a;
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  // Present an op for one edge; returns at posedge+1 after the accepting edge.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = 3'(op);
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts busy cycles; scrambles operands and throws ignored starts meanwhile.
  task automatic wait_busy(input bit noisy, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 500) begin
      n++;
      bus.a = $urandom;
      bus.b = $urandom;
      if (noisy) begin
        bus.start = ($urandom_range(0, 2) == 0);
        bus.op    = 3'($urandom_range(0, 7));
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.hi_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", bus.lo_out); end
  endtask

  task automatic test_mult_signed();
    int n;
    issue(0, 32'hFFFF_FFFE, 32'd3);
    model_op(0, 32'hFFFF_FFFE, 32'd3);
    n_cmp++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin n_bad++; $display("FAIL mult_hold: got %h/%h want 0/0", bus.hi_out, bus.lo_out); end
    wait_busy(1'b0, n);
    n_cmp++; if (n !== MUL_N) begin n_bad++; $display("FAIL mult_busy: got %0d want %0d", n, MUL_N); end
    n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo_out); end
  endtask

  task automatic test_multu();
    int n;
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    model_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy(1'b0, n);
    n_cmp++; if (n !== MUL_N) begin n_bad++; $display("FAIL multu_busy: got %0d want %0d", n, MUL_N); end
    n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", bus.lo_out); end
  endtask

  task automatic test_div();
    int n;
    issue(2, 32'hFFFF_FFF9, 32'd2);
    model_op(2, 32'hFFFF_FFF9, 32'd2);
    wait_busy(1'b0, n);
    n_cmp++; if (n !== DIV_N) begin n_bad++; $display("FAIL div_busy: got %0d want %0d", n, DIV_N); end
    n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", bus.hi_out); end
  endtask

  task automatic test_div_overflow();
    int n;
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
    model_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(1'b0, n);
    n_cmp++; if (bus.lo_out !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo: got %h want 80000000", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'h0) begin n_bad++; $display("FAIL divovf_hi: got %h want 0", bus.hi_out); end
  endtask

  task automatic test_divu_zero();
    int n;
    issue(4, 32'h11, 32'h0);
    model_op(4, 32'h11, 32'h0);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    issue(5, 32'h22, 32'h0);
    model_op(5, 32'h22, 32'h0);
    issue(3, 32'd7, 32'd0);
    model_op(3, 32'd7, 32'd0);
    wait_busy(1'b0, n);
    n_cmp++; if (n !== DIV_N) begin n_bad++; $display("FAIL divz_busy: got %0d want %0d", n, DIV_N); end
    n_cmp++; if (bus.hi_out !== 32'h11) begin n_bad++; $display("FAIL divz_hi: got %h want 00000011", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h22) begin n_bad++; $display("FAIL divz_lo: got %h want 00000022", bus.lo_out); end
  endtask

  // DIV, ignored MTLO at busy cycle 3, reset at busy cycle 6.
  task automatic test_abort();
    issue(2, 32'd100, 32'd7);                 // busy cycle 1
    @(posedge clk); #1;                       // cycle 2
    @(posedge clk); #1;                       // cycle 3
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h55;
    @(posedge clk); #1;                       // cycle 4
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_mid: got %b want 1", bus.busy); end
    n_cmp++; if (bus.lo_out !== m_lo) begin n_bad++; $display("FAIL abort_mtlo_ignored: got %h want %h", bus.lo_out, m_lo); end
    @(posedge clk); #1;                       // cycle 5
    @(posedge clk); #1;                       // cycle 6
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin n_bad++; $display("FAIL abort_hilo: got %h/%h want 0/0", bus.hi_out, bus.lo_out); end
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin n_bad++; $display("FAIL abort_no_late_result: got %b %h/%h want 0 0/0", bus.busy, bus.hi_out, bus.lo_out); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4, 32'h0000_ABCD, 32'h0);
    model_op(4, 32'h0000_ABCD, 32'h0);
    n_cmp++; if (bus.hi_out !== 32'h0000_ABCD) begin n_bad++; $display("FAIL b2b_mthi: got %h want 0000abcd", bus.hi_out); end
    issue(0, 32'd2, 32'd3);
    model_op(0, 32'd2, 32'd3);
    wait_busy(1'b0, n);
    n_cmp++; if (n !== MUL_N) begin n_bad++; $display("FAIL b2b_busy: got %0d want %0d", n, MUL_N); end
    n_cmp++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'd6) begin n_bad++; $display("FAIL b2b_result: got %h/%h want 0/6", bus.hi_out, bus.lo_out); end
  endtask

  task automatic test_ignored_ops();
    for (int k = 6; k <= 7; k++) begin
      issue(k, $urandom, $urandom);
      n_cmp++; if (bus.busy !== 1'b0 || bus.hi_out !== m_hi || bus.lo_out !== m_lo) begin n_bad++; $display("FAIL nop%0d: got %b %h/%h want 0 %h/%h", k, bus.busy, bus.hi_out, bus.lo_out, m_hi, m_lo); end
    end
  endtask

  task automatic test_random();
    int          op;
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 7);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model_op(op, a, b);
      exp_q.push_back(m_hi);
      exp_q.push_back(m_lo);
      issue(op, a, b);
      wait_busy(1'b1, n);
      n_cmp++; if (n !== op_cycles(op)) begin n_bad++; $display("FAIL rnd_busy it=%0d op=%0d: got %0d want %0d", it, op, n, op_cycles(op)); end
      e_hi = exp_q.pop_front();
      e_lo = exp_q.pop_front();
      n_cmp++; if (bus.hi_out !== e_hi || bus.lo_out !== e_lo) begin n_bad++; $display("FAIL rnd_hilo it=%0d op=%0d a=%h b=%h: got %h/%h want %h/%h", it, op, a, b, bus.hi_out, bus.lo_out, e_hi, e_lo); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd7;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_div_overflow();
    test_divu_zero();
    test_abort();
    test_back_to_back();
    test_ignored_ops();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
